seq_detector_cfg: RTL and testbench

//  Parametrised serial sequence detector; successor to the fixed 4-bit pattern detectors.

---
 rtl/seq_det_pkg.sv | 13 +
 rtl/sat_counter.sv | 28 ++
 rtl/seq_detector_cfg.sv | 108 ++++++++++
 tb/tb_seq_detector_cfg.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the configurable serial sequence detector.
package seq_det_pkg;

    localparam int unsigned MODE_MEALY  = 0;
    localparam int unsigned MODE_MOORE  = 1;
    localparam int unsigned PAT_LEN_MIN = 2;
    localparam int unsigned PAT_LEN_MAX = 32;

    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max);
        return (val >= max) ? max : val + 32'd1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter
    import seq_det_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONES = '1;

    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= W'(sat_inc(32'(count_q), 32'(ONES)));
        end
    end

    assign count = count_q;

endmodule

// File: rtl/seq_detector_cfg.sv
// Serial sequence detector with runtime-loadable pattern/overlap mode and a saturating
// match counter; output timing (Mealy or Moore) is fixed per instance.
module seq_detector_cfg
    import seq_det_pkg::*;
#(
    parameter int unsigned               PAT_LEN = 4,
    parameter logic [PAT_LEN_MAX-1:0]    PATTERN = 32'b1011,
    parameter bit                        OVERLAP = 1'b1,
    parameter int unsigned               MOORE   = MODE_MEALY,
    parameter int unsigned               CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               din_valid,
    input  logic               din,
    input  logic               cfg_load,
    input  logic [PAT_LEN-1:0] cfg_pattern,
    input  logic               cfg_overlap,
    output logic               dout,
    output logic [CNT_W-1:0]   match_count
);

    localparam int unsigned      FW       = (PAT_LEN > 2) ? $clog2(PAT_LEN) : 1;
    localparam logic [FW-1:0]    FILL_MAX = FW'(PAT_LEN - 1);

    if (PAT_LEN < PAT_LEN_MIN || PAT_LEN > PAT_LEN_MAX) begin : g_bad_len
        $error("seq_detector_cfg: PAT_LEN %0d outside legal range", PAT_LEN);
    end

    if (PAT_LEN < PAT_LEN_MAX) begin : g_pat_chk
        if ((PATTERN >> PAT_LEN) != '0) begin : g_bad_pat
            $error("seq_detector_cfg: PATTERN wider than PAT_LEN");
        end
    end

    logic [PAT_LEN-1:0] pat_q;
    logic               ovl_q;
    logic [PAT_LEN-2:0] hist_q, hist_d;
    logic [FW-1:0]      fill_q, fill_d;
    logic [PAT_LEN-1:0] cand;
    logic               accept;
    logic               hit;

    // Newest bit sits in the LSB, so the oldest bit lines up with the pattern MSB.
    assign cand = {hist_q, din};

    always_comb begin
        accept = din_valid & ~cfg_load;
        hit    = accept & ~reset & (fill_q == FILL_MAX) & (cand == pat_q);
        hist_d = hist_q;
        fill_d = fill_q;
        if (cfg_load) begin
            fill_d = '0;
        end else if (accept) begin
            hist_d = cand[PAT_LEN-2:0];
            // Non-overlapping mode demands a full set of fresh bits after each match.
            if (hit && !ovl_q) begin
                fill_d = '0;
            end else begin
                fill_d = FW'(sat_inc(32'(fill_q), 32'(FILL_MAX)));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pat_q  <= PATTERN[PAT_LEN-1:0];
            ovl_q  <= OVERLAP;
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            if (cfg_load) begin
                pat_q <= cfg_pattern;
                ovl_q <= cfg_overlap;
            end
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

    if (MOORE == MODE_MOORE) begin : g_moore
        logic dout_q;

        // hit is already low on a cfg_load cycle, which clears any pending pulse.
        always_ff @(posedge clk) begin
            if (reset) begin
                dout_q <= 1'b0;
            end else begin
                dout_q <= hit;
            end
        end

        assign dout = dout_q;
    end else begin : g_mealy
        assign dout = hit;
    end

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cfg_load),
        .en    (hit),
        .count (match_count)
    );

endmodule

// File: tb/tb_seq_detector_cfg.sv
// Scoreboard bench: three detector instances (Mealy default, Moore, 2-bit counter with 1111)
// share one stimulus stream and are checked against a bit-queue reference model.
module tb_seq_detector_cfg;

    logic       clk = 1'b0;
    logic       reset, din_valid, din, cfg_load, cfg_overlap;
    logic [3:0] cfg_pattern;
    logic       dout_a, dout_b, dout_c;
    logic [7:0] cnt_a, cnt_b;
    logic [1:0] cnt_c;

    always #5 clk = ~clk;

    seq_detector_cfg #(
        .PAT_LEN (4), .PATTERN (32'b1011), .OVERLAP (1'b1), .MOORE (0), .CNT_W (8)
    ) u_dut_a (
        .clk (clk), .reset (reset), .din_valid (din_valid), .din (din),
        .cfg_load (cfg_load), .cfg_pattern (cfg_pattern), .cfg_overlap (cfg_overlap),
        .dout (dout_a), .match_count (cnt_a)
    );

    seq_detector_cfg #(
        .PAT_LEN (4), .PATTERN (32'b1011), .OVERLAP (1'b1), .MOORE (1), .CNT_W (8)
    ) u_dut_b (
        .clk (clk), .reset (reset), .din_valid (din_valid), .din (din),
        .cfg_load (cfg_load), .cfg_pattern (cfg_pattern), .cfg_overlap (cfg_overlap),
        .dout (dout_b), .match_count (cnt_b)
    );

    seq_detector_cfg #(
        .PAT_LEN (4), .PATTERN (32'b1111), .OVERLAP (1'b1), .MOORE (0), .CNT_W (2)
    ) u_dut_c (
        .clk (clk), .reset (reset), .din_valid (din_valid), .din (din),
        .cfg_load (cfg_load), .cfg_pattern (cfg_pattern), .cfg_overlap (cfg_overlap),
        .dout (dout_c), .match_count (cnt_c)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: index 0 models instances a/b, index 1 models instance c.
    logic [3:0] def_pat [2] = '{4'b1011, 4'b1111};
    int         cmax    [2] = '{255, 3};
    logic [3:0] m_pat   [2];
    bit         m_ovl   [2];
    logic [2:0] m_hist  [2];
    int         m_len   [2];
    int         m_cnt   [2];
    bit         prev_hit_a;

    typedef struct {
        bit da, db, dc;
        int ca, cb, cc;
    } exp_t;

    exp_t sb[$];

    function automatic bit model_hit(input int m);
        return din_valid && !cfg_load && !reset && (m_len[m] >= 3) &&
               ({m_hist[m], din} == m_pat[m]);
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_pat[m]  = def_pat[m];
            m_ovl[m]  = 1'b1;
            m_hist[m] = '0;
            m_len[m]  = 0;
            m_cnt[m]  = 0;
        end
        prev_hit_a = 1'b0;
    endtask

    task automatic model_update(input bit h0, input bit h1);
        bit h[2];
        h[0] = h0;
        h[1] = h1;
        for (int m = 0; m < 2; m++) begin
            if (reset) begin
                m_pat[m] = def_pat[m];
                m_ovl[m] = 1'b1;
                m_len[m] = 0;
                m_cnt[m] = 0;
            end else if (cfg_load) begin
                m_pat[m] = cfg_pattern;
                m_ovl[m] = cfg_overlap;
                m_len[m] = 0;
                m_cnt[m] = 0;
            end else if (din_valid) begin
                m_hist[m] = {m_hist[m][1:0], din};
                m_len[m]++;
                if (h[m]) begin
                    if (m_cnt[m] < cmax[m]) m_cnt[m]++;
                    if (!m_ovl[m]) m_len[m] = 0;
                end
            end
        end
    endtask

    // One clock of stimulus: push the expectation, compare at negedge, advance model at posedge.
    task automatic step(input bit r, input bit v, input bit d, input bit ld = 1'b0,
                        input logic [3:0] p = 4'b0000, input bit o = 1'b0);
        exp_t e;
        exp_t g;
        bit   ha, hc;
        reset       = r;
        din_valid   = v;
        din         = d;
        cfg_load    = ld;
        cfg_pattern = p;
        cfg_overlap = o;
        ha   = model_hit(0);
        hc   = model_hit(1);
        e.da = ha;
        e.db = prev_hit_a;
        e.dc = hc;
        e.ca = m_cnt[0];
        e.cb = m_cnt[0];
        e.cc = m_cnt[1];
        sb.push_back(e);
        @(negedge clk);
        g = sb.pop_front();
        check_val("dout_a", 32'(dout_a), 32'(g.da));
        check_val("dout_b", 32'(dout_b), 32'(g.db));
        check_val("dout_c", 32'(dout_c), 32'(g.dc));
        check_val("cnt_a", 32'(cnt_a), 32'(g.ca));
        check_val("cnt_b", 32'(cnt_b), 32'(g.cb));
        check_val("cnt_c", 32'(cnt_c), 32'(g.cc));
        @(posedge clk);
        model_update(ha, hc);
        prev_hit_a = ha;
        #1;
    endtask

    task automatic feed(input logic [7:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            step(1'b0, 1'b1, bits[i]);
        end
    endtask

    initial begin
        reset       = 1'b1;
        din_valid   = 1'b0;
        din         = 1'b0;
        cfg_load    = 1'b0;
        cfg_pattern = '0;
        cfg_overlap = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // Reset state, then overlapping default pattern over 1011011
        step(1'b1, 1'b0, 1'b0);
        feed(8'b0101_1011, 7);
        step(1'b0, 1'b0, 1'b0);
        check_val("ovl_count", 32'(cnt_a), 32'd2);

        // Reload same pattern without overlap
        step(1'b0, 1'b1, 1'b1, 1'b1, 4'b1011, 1'b0);
        feed(8'b0101_1011, 7);
        step(1'b0, 1'b0, 1'b0);
        check_val("novl_count", 32'(cnt_a), 32'd1);

        // Gap of invalid cycles with din toggling
        step(1'b1, 1'b0, 1'b0);
        feed(8'b0000_0101, 3);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, i[0]);
        step(1'b0, 1'b1, 1'b1);
        check_val("gap_count", 32'(cnt_a), 32'd1);

        // cfg_load discards din of its cycle and restarts the window
        step(1'b1, 1'b0, 1'b0);
        feed(8'b0000_0101, 3);
        step(1'b0, 1'b1, 1'b1, 1'b1, 4'b1101, 1'b1);
        feed(8'b0000_0110, 3);
        check_val("load_nohit", 32'(cnt_a), 32'd0);
        step(1'b0, 1'b1, 1'b1);
        check_val("load_count", 32'(cnt_a), 32'd1);

        // Saturation on instance c with all-ones pattern
        step(1'b1, 1'b0, 1'b0);
        feed(8'b1111_1111, 8);
        check_val("sat_count", 32'(cnt_c), 32'd3);

        // Reset mid-sequence (with valid data present) clears history
        step(1'b1, 1'b0, 1'b0);
        feed(8'b0000_0101, 3);
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        check_val("rst_mid_count", 32'(cnt_a), 32'd0);

        // Moore pulse pending when cfg_load arrives is still visible that cycle only
        step(1'b1, 1'b0, 1'b0);
        feed(8'b0000_1011, 4);
        step(1'b0, 1'b1, 1'b1, 1'b1, 4'b1011, 1'b1);
        step(1'b0, 1'b0, 1'b0);

        // Random traffic with occasional reloads and resets
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 39) == 0, 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
